// File: rtl/issue_pkg.sv
// Shared types for the issue stall controller: FSM state and buffered entry layout.
package issue_pkg;

  localparam int ISSUE_XLEN = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [ISSUE_XLEN-1:0] pc;
    logic [ISSUE_XLEN-1:0] instr;
  } issue_entry_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction buffer; clr empties it in one cycle and wins over push/pop.
module issue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/issue_stall_ctrl.sv
// Issue buffer with RAW-stall hold and branch-kill flush control.
// Optional ISSUE_STALL_PERF_EN adds saturating stall/kill performance counters.
module issue_stall_ctrl
  import issue_pkg::*;
#(
  parameter int XLEN         = ISSUE_XLEN,
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            in_ready,
  input  logic            stall,
  input  logic [1:0]      stallnum,
  input  logic            kill,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
`ifdef ISSUE_STALL_PERF_EN
  ,
  output logic [15:0]     perf_stall_cycles,
  output logic [15:0]     perf_kills
`endif
);

  localparam int ENTRY_W = 2 * XLEN;

  issue_state_t       state;
  logic [1:0]         hold_cnt;
  logic [1:0]         flush_cnt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;

  // A kill cycle refuses input so the dropped push never reaches the buffer.
  assign in_ready  = !full && (state != ST_FLUSH) && !kill;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty && (state == ST_RUN) && !stall && !kill;
  assign pop       = out_valid && out_ready;
  assign wdata     = {in_pc, in_instr};
  assign out_pc    = rdata[ENTRY_W-1:XLEN];
  assign out_instr = rdata[XLEN-1:0];

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (kill),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      hold_cnt  <= '0;
      flush_cnt <= '0;
    end else if (kill) begin
      state     <= ST_FLUSH;
      flush_cnt <= 2'(FLUSH_CYCLES - 1);
    end else begin
      case (state)
        ST_RUN: begin
          if (stall && (stallnum != 2'd0)) begin
            state    <= ST_HOLD;
            hold_cnt <= stallnum - 2'd1;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == 2'd0) state <= ST_RUN;
          else                  hold_cnt <= hold_cnt - 2'd1;
        end
        ST_FLUSH: begin
          if (flush_cnt == 2'd0) state <= ST_RUN;
          else                   flush_cnt <= flush_cnt - 2'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef ISSUE_STALL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_kills        <= '0;
    end else begin
      if ((state == ST_HOLD) || stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
      if (kill)                        perf_kills        <= sat_inc(perf_kills);
    end
  end
`endif

endmodule

// File: tb/tb_issue_stall_ctrl.sv
// Self-checking bench for issue_stall_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_issue_stall_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int FC    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            stall;
  logic [1:0]      stallnum;
  logic            kill;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;
`ifdef ISSUE_STALL_PERF_EN
  logic [15:0]     perf_stall_cycles;
  logic [15:0]     perf_kills;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of {pc,instr} plus remaining blocked-cycle budgets.
  logic [63:0] mq[$];
  int          hold_left;
  int          flush_left;
  logic        exp_ir;
  logic        exp_ov;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  always #5 clk = ~clk;

  issue_stall_ctrl #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .stall     (stall),
    .stallnum  (stallnum),
    .kill      (kill),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready)
`ifdef ISSUE_STALL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_kills        (perf_kills)
`endif
  );

  // Drive one cycle of inputs and derive the expected outputs from the model.
  task automatic set_in(input logic iv, input logic [31:0] pc, input logic st,
                        input logic [1:0] sn, input logic k, input logic ordy);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = pc ^ 32'hA5A5_0013;
    stall     = st;
    stallnum  = sn;
    kill      = k;
    out_ready = ordy;
    #2;
    exp_ir    = (mq.size() < DEPTH) && (flush_left == 0) && !k;
    exp_ov    = (mq.size() > 0) && (hold_left == 0) && (flush_left == 0) && !st && !k;
    exp_pc    = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
    exp_instr = (mq.size() > 0) ? mq[0][31:0] : 32'h0;
  endtask

  // Advance the model by the current cycle's inputs, then clock the DUT.
  task automatic tick();
    if (rst) begin
      mq.delete();
      hold_left  = 0;
      flush_left = 0;
    end else if (kill) begin
      mq.delete();
      flush_left = FC;
      hold_left  = 0;
    end else begin
      if (exp_ov && out_ready) void'(mq.pop_front());
      if (in_valid && exp_ir) mq.push_back({in_pc, in_instr});
      if (flush_left > 0)                    flush_left--;
      else if (hold_left > 0)                hold_left--;
      else if (stall && (stallnum != 2'd0))  hold_left = int'(stallnum);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(i < 3, 32'h100 + 32'(4 * i), 1'b0, 2'd0, 1'b0, 1'b1);
      if (i < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_in_ready cyc=%0d got=%0b exp=1", i, in_ready);
        end
      end
      checks++;
      if (out_valid !== (i > 0)) begin
        failures++; $display("FAIL b2b_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, i > 0);
      end
      if (i > 0) begin
        checks++;
        if (out_pc !== 32'h100 + 32'(4 * (i - 1))) begin
          failures++; $display("FAIL b2b_out_pc cyc=%0d got=%h exp=%h", i, out_pc, 32'h100 + 32'(4 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    set_in(1'b1, 32'h200, 1'b0, 2'd0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'h0, i == 0, 2'd2, 1'b0, 1'b1);
      checks++;
      if (out_valid !== (i == 3)) begin
        failures++; $display("FAIL hold_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, i == 3);
      end
      if (i == 3) begin
        checks++;
        if (out_pc !== 32'h200) begin
          failures++; $display("FAIL hold_out_pc got=%h exp=00000200", out_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    set_in(1'b1, 32'h300, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h304, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h308, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
      failures++; $display("FAIL full_head_stable got=%0b/%h exp=1/00000300", out_valid, out_pc);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== (i < 2)) begin
        failures++; $display("FAIL full_drain_valid cyc=%0d got=%0b exp=%0b", i, out_valid, i < 2);
      end
      if (i < 2) begin
        checks++;
        if (out_pc !== 32'h300 + 32'(4 * i)) begin
          failures++; $display("FAIL full_drain_pc cyc=%0d got=%h exp=%h", i, out_pc, 32'h300 + 32'(4 * i));
        end
      end
      tick();
    end
  endtask

  task automatic test_kill();
    do_reset();
    set_in(1'b1, 32'h400, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 32'h404, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h500, 1'b0, 2'd0, i == 0, 1'b1);
      checks++;
      if (in_ready !== (i == 3)) begin
        failures++; $display("FAIL kill_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, i == 3);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL kill_out_valid cyc=%0d got=%0b exp=0", i, out_valid);
      end
      tick();
    end
    set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h500) begin
      failures++; $display("FAIL kill_refill got=%0b/%h exp=1/00000500", out_valid, out_pc);
    end
    tick();
  endtask

  task automatic test_kill_stall_rst();
    do_reset();
    set_in(1'b1, 32'h600, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 1'b1, 2'd3, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
      tick();
    end
    set_in(1'b1, 32'h604, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL ks_in_ready got=%0b exp=1", in_ready);
    end
    tick();
    set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h604) begin
      failures++; $display("FAIL ks_no_hold got=%0b/%h exp=1/00000604", out_valid, out_pc);
    end
    tick();
    set_in(1'b1, 32'h700, 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    set_in(1'b1, 32'h704, 1'b0, 2'd0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_in_flush got=%0b/%0b exp=1/0", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(9, 0) < 7, $urandom, $urandom_range(9, 0) < 2,
             2'($urandom_range(3, 0)), $urandom_range(29, 0) == 0, $urandom_range(9, 0) < 7);
      checks++;
      if (in_ready !== exp_ir) begin
        failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, exp_ir);
      end
      checks++;
      if (out_valid !== exp_ov) begin
        failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, exp_ov);
      end
      if (exp_ov) begin
        checks++;
        if (out_pc !== exp_pc || out_instr !== exp_instr) begin
          failures++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, out_pc, out_instr, exp_pc, exp_instr);
        end
      end
      tick();
    end
  endtask

`ifdef ISSUE_STALL_PERF_EN
  task automatic test_perf();
    do_reset();
    set_in(1'b1, 32'h800, 1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 32'h0, i == 0, 2'd3, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (perf_stall_cycles !== 16'd4) begin
      failures++; $display("FAIL perf_stall got=%0d exp=4", perf_stall_cycles);
    end
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 2'd0, (i == 0) || (i == 4), 1'b1);
      tick();
    end
    checks++;
    if (perf_kills !== 16'd2) begin
      failures++; $display("FAIL perf_kills got=%0d exp=2", perf_kills);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    hold_left  = 0;
    flush_left = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_full();
    test_kill();
    test_kill_stall_rst();
    test_random();
`ifdef ISSUE_STALL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
